// File: rtl/match_len_pkg.sv
// Shared types and elaboration helpers for the match-length accumulator.
// The MATCH_LEN_ACC_MIN_FILTER_EN build option is handled in match_len_accumulator.
package match_len_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } acc_state_e;

  // True when a len_width-bit field can hold every value 0..max_len.
  function automatic bit len_width_ok(input int max_len, input int len_width);
    return len_width >= $clog2(max_len + 1);
  endfunction

  function automatic int beat_len_width(input int mask_width);
    return $clog2(mask_width + 1);
  endfunction

endpackage

// File: rtl/match_beat_encoder.sv
// Reduces one byte-compare mask to the run of matching bytes starting at bit 0.
// The run length is the position of the lowest set bit of ~in_mask.
module match_beat_encoder
  import match_len_pkg::*;
#(
  parameter int MASK_WIDTH = 16,
  parameter int LEN_WIDTH  = beat_len_width(MASK_WIDTH)
) (
  input  logic [MASK_WIDTH-1:0] in_mask,
  output logic [LEN_WIDTH-1:0]  beat_len,
  output logic                  full
);

  // Scanning downward lets the lowest mismatch win the priority.
  always_comb begin
    beat_len = LEN_WIDTH'(MASK_WIDTH);
    full     = &in_mask;
    for (int i = MASK_WIDTH - 1; i >= 0; i--) begin
      if (!in_mask[i]) beat_len = LEN_WIDTH'(i);
    end
  end

endmodule

// File: rtl/match_len_accumulator.sv
// Sums per-beat match runs for one candidate and emits a tagged, saturated length.
// Define MATCH_LEN_ACC_MIN_FILTER_EN to drop results shorter than MIN_MATCH_LEN.
module match_len_accumulator
  import match_len_pkg::*;
#(
  parameter int MASK_WIDTH      = 16,
  parameter int MAX_MATCH_LEN   = 258,
  parameter int MATCH_LEN_WIDTH = 9,
  parameter int TAG_WIDTH       = 8,
  parameter int MIN_MATCH_LEN   = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [MASK_WIDTH-1:0]      in_mask,
  input  logic                       in_first,
  input  logic                       in_last,
  input  logic [TAG_WIDTH-1:0]       in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [MATCH_LEN_WIDTH-1:0] out_match_len,
  output logic [TAG_WIDTH-1:0]       out_tag,
  output logic                       out_truncated,
  output logic                       err_proto
);

  localparam int BEAT_W = beat_len_width(MASK_WIDTH);
  localparam int SUM_W  = MATCH_LEN_WIDTH + 1;
  localparam logic [SUM_W-1:0]           MAX_SUM = SUM_W'(MAX_MATCH_LEN);
  localparam logic [MATCH_LEN_WIDTH-1:0] MAX_LEN = MATCH_LEN_WIDTH'(MAX_MATCH_LEN);

  if (!len_width_ok(MAX_MATCH_LEN, MATCH_LEN_WIDTH)) begin : g_len_width_check
    $error("MATCH_LEN_WIDTH cannot represent MAX_MATCH_LEN");
  end
  if (MIN_MATCH_LEN > MAX_MATCH_LEN) begin : g_min_len_check
    $error("MIN_MATCH_LEN exceeds MAX_MATCH_LEN");
  end

  acc_state_e                 state_q, state_d;
  logic [MATCH_LEN_WIDTH-1:0] acc_len_q, acc_len_d;
  logic [TAG_WIDTH-1:0]       acc_tag_q, acc_tag_d;
  logic                       out_valid_q, out_valid_d;
  logic [MATCH_LEN_WIDTH-1:0] out_len_q, out_len_d;
  logic [TAG_WIDTH-1:0]       out_tag_q, out_tag_d;
  logic                       out_trunc_q, out_trunc_d;
  logic                       err_q, err_d;

  logic [BEAT_W-1:0]          beat_len;
  logic                       full;
  logic                       accept;
  logic                       start_new;
  logic [MATCH_LEN_WIDTH-1:0] base;
  logic [SUM_W-1:0]           sum;
  logic                       sat;
  logic [MATCH_LEN_WIDTH-1:0] len_clamped;
  logic [TAG_WIDTH-1:0]       cand_tag;
  logic                       done;
  logic                       emit;

  match_beat_encoder #(
    .MASK_WIDTH (MASK_WIDTH),
    .LEN_WIDTH  (BEAT_W)
  ) u_encoder (
    .in_mask  (in_mask),
    .beat_len (beat_len),
    .full     (full)
  );

  assign in_ready      = !out_valid_q || out_ready;
  assign out_valid     = out_valid_q;
  assign out_match_len = out_len_q;
  assign out_tag       = out_tag_q;
  assign out_truncated = out_trunc_q;
  assign err_proto     = err_q;

  // A beat seen in IDLE always opens a candidate, whether or not it is flagged first.
  always_comb begin
    accept      = in_valid && in_ready;
    start_new   = in_first || (state_q == IDLE);
    base        = start_new ? '0 : acc_len_q;
    sum         = SUM_W'(base) + SUM_W'(beat_len);
    sat         = sum >= MAX_SUM;
    len_clamped = sat ? MAX_LEN : sum[MATCH_LEN_WIDTH-1:0];
    cand_tag    = start_new ? in_tag : acc_tag_q;
    done        = !full || in_last || sat;
`ifdef MATCH_LEN_ACC_MIN_FILTER_EN
    emit        = len_clamped >= MATCH_LEN_WIDTH'(MIN_MATCH_LEN);
`else
    emit        = 1'b1;
`endif

    state_d     = state_q;
    acc_len_d   = acc_len_q;
    acc_tag_d   = acc_tag_q;
    out_valid_d = out_valid_q && !out_ready;
    out_len_d   = out_len_q;
    out_tag_d   = out_tag_q;
    out_trunc_d = out_trunc_q;
    err_d       = err_q;

    if (accept) begin
      if ((in_first && state_q == ACCUM) || (!in_first && state_q == IDLE)) begin
        err_d = 1'b1;
      end
      if (done) begin
        state_d   = IDLE;
        acc_len_d = '0;
        if (emit) begin
          out_valid_d = 1'b1;
          out_len_d   = len_clamped;
          out_tag_d   = cand_tag;
          out_trunc_d = sat;
        end
      end else begin
        state_d   = ACCUM;
        acc_len_d = sum[MATCH_LEN_WIDTH-1:0];
        acc_tag_d = cand_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_len_q   <= '0;
      acc_tag_q   <= '0;
      out_valid_q <= 1'b0;
      out_len_q   <= '0;
      out_tag_q   <= '0;
      out_trunc_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_len_q   <= acc_len_d;
      acc_tag_q   <= acc_tag_d;
      out_valid_q <= out_valid_d;
      out_len_q   <= out_len_d;
      out_tag_q   <= out_tag_d;
      out_trunc_q <= out_trunc_d;
      err_q       <= err_d;
    end
  end

endmodule
